// File: rtl/final_adder_stage_4.sv
// final_adder_stage_4 -- terminal stage of the final-adder pipeline.
//
// Accepts float pairs from stage 3 on its one-cycle done strobe and buffers
// them in a small FIFO. Each pair is summed by a fixed-latency fp_add core,
// and each sum is offered downstream on a valid/ready handshake. Stage 3 is
// never back-pressured. When a pair arrives and cannot be stored, it is
// dropped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (also fp_add aclr)
//   clk_en                   global enable; low freezes the whole block
//   in_done                  single-cycle strobe, operands valid with it
//   to_add_one, to_add_two   IEEE-754 single addends
//   sum, sum_valid           result and its valid flag (held until accepted)
//   sum_ready                downstream accept
//   busy                     registered: FSM not IDLE or FIFO non-empty
//   overflow                 sticky dropped-pair flag; exists only when the
//                            macro FINAL_ADDER_OVERFLOW_FLAG_EN is defined
//
// fp_add (in this file) is a single-precision adder with round-to-nearest-even.
// Denormal inputs and outputs are flushed to zero. Its output is valid
// LATENCY enabled cycles after its operands become stable.

module fp_add #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);
  logic [31:0]       x, y, sum_comb;
  logic [7:0]        ex, ey, d;
  logic [4:0]        sh, lz;
  logic [26:0]       xm, ym, ys_raw, lost, ys, n;
  logic [27:0]       s;
  logic [24:0]       mr;
  logic [22:0]       mant;
  logic signed [9:0] e_norm;
  logic              eff_sub, round_up;

  always_comb begin
    // Order the operands by magnitude so the alignment shift is never negative.
    if (dataa[30:0] >= datab[30:0]) begin
      x = dataa;
      y = datab;
    end else begin
      x = datab;
      y = dataa;
    end
    ex      = x[30:23];
    ey      = y[30:23];
    eff_sub = x[31] ^ y[31];
    xm      = {(ex != 8'd0), x[22:0], 3'b000};
    ym      = (ey != 8'd0) ? {1'b1, y[22:0], 3'b000} : 27'd0;
    d       = ex - ey;
    sh      = (d > 8'd26) ? 5'd27 : d[4:0];
    ys_raw  = ym >> sh;
    lost    = ym & ~({27{1'b1}} << sh);
    ys      = {ys_raw[26:1], ys_raw[0] | (|lost)};
    s       = eff_sub ? ({1'b0, xm} - {1'b0, ys}) : ({1'b0, xm} + {1'b0, ys});
    lz      = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    if (s[27]) begin
      n      = {s[27:2], s[1] | s[0]};
      e_norm = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      n      = s[26:0] << lz;
      e_norm = $signed({2'b00, ex}) - $signed({5'b00000, lz});
    end
    // Guard/round/sticky live in n[2:0]; ties go to even.
    round_up = n[2] & (n[1] | n[0] | n[3]);
    mr       = {1'b0, n[26:3]} + {24'd0, round_up};
    if (mr[24]) begin
      mant   = mr[23:1];
      e_norm = e_norm + 10'sd1;
    end else begin
      mant   = mr[22:0];
    end

    if (ex == 8'hFF) begin
      if (x[22:0] != 23'd0 || (ey == 8'hFF && eff_sub)) sum_comb = 32'h7FC0_0000;
      else                                              sum_comb = {x[31], 8'hFF, 23'd0};
    end else if (s == 28'd0) begin
      sum_comb = {x[31] & y[31], 31'd0};
    end else if (e_norm >= 10'sd255) begin
      sum_comb = {x[31], 8'hFF, 23'd0};
    end else if (e_norm <= 10'sd0) begin
      sum_comb = {x[31], 31'd0};
    end else begin
      sum_comb = {x[31], e_norm[7:0], mant};
    end
  end

  // LATENCY-1 register stages after the combinational core. The result is
  // sampled by the consumer on the LATENCY-th enabled edge.
  generate
    if (LATENCY > 1) begin : g_pipe
      logic [31:0] pipe [LATENCY-1];
      always_ff @(posedge clk) begin
        if (aclr) begin
          for (int i = 0; i < LATENCY-1; i++) pipe[i] <= '0;
        end else if (clk_en) begin
          pipe[0] <= sum_comb;
          for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign result = pipe[LATENCY-2];
    end else begin : g_comb
      assign result = sum_comb;
    end
  endgenerate
endmodule

module final_adder_stage_4 #(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int ADD_LATENCY      = 7,
  parameter int FIFO_DEPTH       = 4,
  parameter int PTR_WIDTH        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        in_done,
  input  logic [FLOAT_DATA_WIDTH-1:0] to_add_one,
  input  logic [FLOAT_DATA_WIDTH-1:0] to_add_two,
  output logic [FLOAT_DATA_WIDTH-1:0] sum,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic                        busy
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
  ,
  output logic                        overflow
`endif
);
  localparam int W     = FLOAT_DATA_WIDTH;
  localparam int CW    = PTR_WIDTH + 1;
  localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ADD, OUT} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_next;
  logic [2*W-1:0]         mem [FIFO_DEPTH];
  logic [2*W-1:0]         head;
  logic [W-1:0]           op_a, op_b, add_result;
  logic                   fifo_empty, fifo_full, handshake, pop, push, cnt_last;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign cnt_last   = (cnt == CNT_W'(ADD_LATENCY - 1));
  assign handshake  = (state == OUT) && sum_valid && sum_ready;
  assign pop        = clk_en && !fifo_empty && ((state == IDLE) || handshake);
  // A full FIFO still takes a pair when the head leaves on the same edge.
  assign push       = clk_en && in_done && (!fifo_full || pop);
  assign count_next = count + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ADD;
      ADD:     if (cnt_last) state_next = OUT;
      OUT:     if (handshake) state_next = fifo_empty ? IDLE : ADD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {to_add_one, to_add_two};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clk_en) begin
      state <= state_next;
      count <= count_next;
      busy  <= (state_next != IDLE) || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        op_a   <= head[2*W-1:W];
        op_b   <= head[W-1:0];
        cnt    <= '0;
      end
      if (state == ADD) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt_last) begin
          sum       <= add_result;
          sum_valid <= 1'b1;
        end
      end
      if (handshake) sum_valid <= 1'b0;
    end
  end

`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)                              overflow <= 1'b0;
    else if (clk_en && in_done && !push)  overflow <= 1'b1;
  end
`endif

  fp_add #(.LATENCY(ADD_LATENCY)) u_fp_add (
    .clk    (clk),
    .aclr   (rst),
    .clk_en (clk_en && (state == ADD)),
    .dataa  (op_a),
    .datab  (op_b),
    .result (add_result)
  );
endmodule

// File: tb/tb_final_adder_stage_4.sv
// Directed testbench for final_adder_stage_4 (default parameters).
module tb_final_adder_stage_4;
  localparam int L = 7;
  localparam logic [31:0] F_1 = 32'h3F80_0000, F_2 = 32'h4000_0000, F_M1 = 32'hBF80_0000;
  localparam logic [31:0] F_H = 32'h3F00_0000, F_3 = 32'h4040_0000, F_4 = 32'h4080_0000;
  localparam logic [31:0] F_M2 = 32'hC000_0000, F_2P5 = 32'h4020_0000;

  logic        clk = 1'b0;
  logic        rst, clk_en, in_done, sum_ready, sum_valid, busy;
  logic [31:0] a, b, sum;
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  final_adder_stage_4 dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_done(in_done),
    .to_add_one(a), .to_add_two(b), .sum(sum), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy)
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded on the falling edge before the accepting edge.
  logic [31:0] got_q[$];
  int          got_edge[$];
  always @(negedge clk) begin
    if (!rst && clk_en && sum_valid && sum_ready) begin
      got_q.push_back(sum);
      got_edge.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Stall-test pairs and their sums; the sixth is the one that overflows.
  logic [31:0] pa[6] = '{F_1, F_2, F_1, F_H, F_M1, F_2};
  logic [31:0] pb[6] = '{F_2, F_2, F_1, F_H, F_M1, F_H};
  logic [31:0] ps[6] = '{F_3, F_4, F_2, F_1, F_M2, F_2P5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [31:0] x, input logic [31:0] y);
    in_done = 1'b1;
    a = x;
    b = y;
    tick(1);
    in_done = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && got_q.size() < target; i++) tick(1);
    check(tag, 32'(got_q.size()), 32'(target));
  endtask

  task automatic check_sums(input string tag, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > base + i) check(tag, got_q[base+i], ps[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, e0;
    rst = 1'b1; clk_en = 1'b1; in_done = 1'b0; sum_ready = 1'b1; a = '0; b = '0;
    tick(2);
    check("reset sum", sum, 32'h0);
    check("reset sum_valid", 32'(sum_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
    check("reset overflow", 32'(overflow), 32'd0);
`endif
    rst = 1'b0;
    tick(1);

    // Single add: 1 + 2 = 3, valid rises ADD_LATENCY+1 edges after the strobe.
    base = got_q.size();
    e0 = cyc;
    strobe(F_1, F_2);
    tick(L);
    check("single valid early", 32'(sum_valid), 32'd0);
    tick(1);
    check("single valid", 32'(sum_valid), 32'd1);
    check("single sum", sum, F_3);
    tick(1);
    check("single valid drop", 32'(sum_valid), 32'd0);
    check("single busy idle", 32'(busy), 32'd0);
    check("single count", 32'(got_q.size()), 32'(base + 1));
    if (got_q.size() > base) check("single edge", 32'(got_edge[base]), 32'(e0 + L + 2));

    // Burst of four pairs on consecutive cycles.
    tick(3);
    base = got_q.size();
    e0 = cyc;
    strobe(F_1, F_1);
    strobe(F_2, F_2);
    strobe(F_M1, F_M1);
    strobe(F_H, F_H);
    wait_got("burst count", base + 4, 100);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > base + i) begin
        check("burst sum", got_q[base+i], (i == 0) ? F_2 : (i == 1) ? F_4 : (i == 2) ? F_M2 : F_1);
        check("burst edge", 32'(got_edge[base+i]), 32'(e0 + L + 2 + i * (L + 1)));
      end
    end
    tick(3);
    check("burst busy idle", 32'(busy), 32'd0);

    // Stall: six pairs with sum_ready low; the sixth is dropped.
    sum_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 6; i++) strobe(pa[i], pb[i]);
    tick(L + 2);
    check("stall valid held", 32'(sum_valid), 32'd1);
    check("stall sum held", sum, F_3);
    check("stall busy", 32'(busy), 32'd1);
    check("stall no handshake", 32'(got_q.size()), 32'(base));
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
    check("stall overflow", 32'(overflow), 32'd1);
`endif
    sum_ready = 1'b1;
    wait_got("stall count", base + 5, 200);
    check_sums("stall sum", base, 5);
    tick(2 * L + 5);
    check("stall no sixth", 32'(got_q.size()), 32'(base + 5));
    check("stall busy idle", 32'(busy), 32'd0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
    check("overflow cleared", 32'(overflow), 32'd0);
`endif

    // Full FIFO in OUT: push and pop on the same edge keeps the pair.
    sum_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 5; i++) strobe(pa[i], pb[i]);
    tick(L + 2);
    check("full in OUT", 32'(sum_valid), 32'd1);
    sum_ready = 1'b1;
    strobe(pa[5], pb[5]);
`ifdef FINAL_ADDER_OVERFLOW_FLAG_EN
    check("full push overflow", 32'(overflow), 32'd0);
`endif
    wait_got("full count", base + 6, 200);
    check_sums("full sum", base, 6);

    // Enable freeze for 10 edges mid-ADD, with a strobe inside the window.
    tick(3);
    base = got_q.size();
    e0 = cyc;
    strobe(F_2, F_H);
    tick(2);
    clk_en = 1'b0;
    tick(3);
    strobe(F_1, F_1);
    tick(6);
    check("freeze busy", 32'(busy), 32'd1);
    clk_en = 1'b1;
    wait_got("freeze count", base + 1, 100);
    if (got_q.size() > base) begin
      check("freeze sum", got_q[base], F_2P5);
      check("freeze edge", 32'(got_edge[base]), 32'(e0 + L + 2 + 10));
    end
    tick(2 * L + 5);
    check("freeze pair dropped", 32'(got_q.size()), 32'(base + 1));
    check("freeze busy idle", 32'(busy), 32'd0);

    // Reset two edges into ADD with two pairs buffered.
    base = got_q.size();
    strobe(F_1, F_2);
    strobe(F_2, F_2);
    strobe(F_1, F_1);
    rst = 1'b1;
    tick(1);
    check("midreset valid", 32'(sum_valid), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(3 * L);
    check("midreset no output", 32'(got_q.size()), 32'(base));
    check("midreset valid later", 32'(sum_valid), 32'd0);
    check("midreset busy later", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/final_adder_stage_4.md
# final_adder_stage_4

Terminal stage of the final-adder pipeline. It takes the pair of IEEE-754 single-precision products that stage 3 emits with its one-cycle `done` strobe. Each pair is buffered in a small FIFO and summed with the team `fp_add` core, which has a fixed latency. Each sum is presented downstream on a valid/ready handshake. The block is the consumer end of stage 3's done-strobe interface, so it never back-pressures stage 3.

## Interface
Parameters:
- `FLOAT_DATA_WIDTH`, default 32: operand/result width (IEEE-754 single).
- `ADD_LATENCY`, default 7: cycles `fp_add` needs from stable operands with `clk_en` high to a valid result; ≥1.
- `FIFO_DEPTH`, default 4: pair buffer entries; power of two, ≥2.
- `PTR_WIDTH`, default 2: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; also drives `fp_add` `aclr`.
- `clk_en`  in  1  global enable; low freezes the whole block.
- `in_done`  in  1  single-cycle strobe from stage 3; operands valid in the same cycle.
- `to_add_one`  in  32  first addend (float).
- `to_add_two`  in  32  second addend (float).
- `sum`  out  32  `to_add_one + to_add_two` (float).
- `sum_valid`  out  1  `sum` valid; held until accepted.
- `sum_ready`  in  1  downstream accepts `sum` when `sum_valid && sum_ready` at a rising edge.
- `busy`  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky dropped-pair flag; present only with `FINAL_ADDER_OVERFLOW_FLAG_EN`.

## Operation
- **FIFO push:** on an edge with `clk_en && in_done`, the pair {`to_add_one`, `to_add_two`} is written.
  - A push is permitted when not full, or when full and a pop occurs on the same edge.
  - Otherwise the pair is dropped.
- **FSM states:** IDLE, ADD, OUT.
- **IDLE:**
  - FIFO non-empty → pop the head into operand registers `op_a`/`op_b`, clear `cnt`, go to ADD.
- **ADD:**
  - `fp_add` `clk_en` = `clk_en`; operands stay stable; `cnt` increments each enabled edge.
  - On the edge where `cnt == ADD_LATENCY-1`: `sum` ← adder result, `sum_valid` ← 1, go to OUT.
- **OUT:**
  - `sum` and `sum_valid` are held.
  - On handshake: `sum_valid` ← 0.
    - FIFO non-empty → pop directly into ADD.
    - FIFO empty → go to IDLE.
- `fp_add` `clk_en` is low outside ADD.
- Arithmetic is IEEE-754 as delivered by `fp_add`; no rounding, NaN or denormal handling is added here.
- `busy` is registered: `(next_state != IDLE) || (next_count != 0)`.

## Timing
- **Reset values:** `sum`=0, `sum_valid`=0, `busy`=0, `overflow`=0. FIFO pointers and count are 0, state is IDLE, `cnt`=0. `rst` overrides `clk_en`.
- **Latency:** for an idle block, `in_done` sampled at edge E0 → pop at E1 → `sum_valid` high after edge E1+`ADD_LATENCY`.
- **Throughput:** with `sum_ready` tied high and the FIFO never empty, one result every `ADD_LATENCY`+1 cycles.
- **`clk_en` low:**
  - No push; `in_done` is ignored and the pair is lost.
  - No state change, `cnt` is held, and the adder is frozen.
  - `sum`/`sum_valid` are held, and no handshake completes.
- **Push and pop on the same edge:** both occur and the count is unchanged. This applies in IDLE or OUT, including when the FIFO is full.
- **`sum_ready` low:** stays in OUT indefinitely; the FIFO keeps absorbing pairs until full.
- **Reset mid-ADD or mid-OUT:** the in-flight result and all buffered pairs are discarded, with the reset values above on the next edge.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`. Full/empty are derived from a `PTR_WIDTH+1`-bit count.

## Configuration
- `FINAL_ADDER_OVERFLOW_FLAG_EN` defined:
  - `overflow` port exists.
  - It is set on any edge with `clk_en && in_done` where the push is refused.
  - It is cleared only by `rst`.
- Undefined: port and logic are absent. Dropped pairs are silent; everything else is identical.

## Test plan
- **Single add:** reset; `in_done` with 0x3F800000, 0x40000000; `sum_ready`=1 → `sum`=0x40400000 with `sum_valid` high for exactly one cycle, `ADD_LATENCY`+1 edges after the strobe; `busy` then returns to 0.
- **Burst:** 4 strobes on consecutive cycles, pairs (1,1), (2,2), (−1,−1), (0.5,0.5); `sum_ready`=1 → `sum` outputs in order: 0x40000000, 0x40800000, 0xC0000000, 0x3F800000, spaced `ADD_LATENCY`+1 cycles apart.
- **Stall/overflow:** hold `sum_ready`=0; send 6 pairs → 1 in OUT and 4 buffered, the 6th dropped and `overflow`=1 (macro on); release `sum_ready` → exactly 5 sums in order.
- **Full push+pop:** FIFO full in OUT; `sum_ready`=1 and `in_done` on the same edge → pair accepted, count stays `FIFO_DEPTH`, and `overflow` stays 0.
- **Enable freeze:** drop `clk_en` for 10 cycles mid-ADD, with an `in_done` during that window → result delayed by exactly 10 cycles, correct value, and the pair during freeze is dropped.
- **Reset mid-op:** `rst` asserted 2 cycles into ADD with 2 pairs buffered → next cycle `sum_valid`=0, `busy`=0, and no further `sum_valid` without new input.
